// File: rtl/udp_tx_arb.sv
// udp_tx_arb: two-requester round-robin arbiter in front of a single UDP
// transmit engine.
//
// Ports
//   clk                        MII transmit clock (rising edge)
//   rst                        asynchronous active-high reset
//   ch0_req/ch1_req            level packet request, held until chN_done
//   ch0_byte_num/ch1_byte_num  payload byte count of the pending packet
//   ch0_data/ch1_data          payload word returned for chN_rd
//   ch0_rd/ch1_rd              payload read strobe to the granted requester
//   ch0_grant/ch1_grant        requester owns the transmit path
//   ch0_done/ch1_done          one-clock completion pulse
//   tx_start_en                one-clock start pulse to the sender
//   tx_byte_num                registered byte count for the sender
//   tx_data                    payload word from the granted requester
//   tx_req                     payload read request from the sender
//   tx_done                    one-clock packet-sent pulse from the sender
//   timeout_err                one-clock pulse when the sender never answers
module udp_tx_arb #(
  parameter int GAP_CYCLES = 24,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_req,
  input  logic        ch1_req,
  input  logic [15:0] ch0_byte_num,
  input  logic [15:0] ch1_byte_num,
  input  logic [31:0] ch0_data,
  input  logic [31:0] ch1_data,
  output logic        ch0_rd,
  output logic        ch1_rd,
  output logic        ch0_grant,
  output logic        ch1_grant,
  output logic        ch0_done,
  output logic        ch1_done,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] tx_data,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        timeout_err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_ZERO,
    S_GAP
  } state_t;

  state_t          state_q;
  logic            sel_q;       // channel currently granted
  logic            prio_q;      // channel that wins a tie (0 = ch0)
  logic            grant0_q, grant1_q;
  logic            done0_q, done1_q;
  logic            start_q;
  logic            tout_q;
  logic [15:0]     byte_num_q;
  logic [TW-1:0]   busy_cnt_q;
  logic [GW-1:0]   gap_cnt_q;

  logic            win_d;
  logic [15:0]     win_bn_d;
  logic            busy;

  // A lone requester always wins; a tie goes to the favoured channel.
  always_comb begin
    win_d = prio_q;
    if (ch0_req && !ch1_req) win_d = 1'b0;
    else if (ch1_req && !ch0_req) win_d = 1'b1;
    win_bn_d = win_d ? ch1_byte_num : ch0_byte_num;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      prio_q     <= 1'b0;
      grant0_q   <= 1'b0;
      grant1_q   <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      start_q    <= 1'b0;
      tout_q     <= 1'b0;
      byte_num_q <= '0;
      busy_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      start_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      tout_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ch0_req || ch1_req) begin
            sel_q      <= win_d;
            grant0_q   <= ~win_d;
            grant1_q   <= win_d;
            byte_num_q <= win_bn_d;
            if (win_bn_d == '0) begin
              // Empty packet: done is shown during ZERO itself so the
              // requester drops its request before IDLE samples it again.
              done0_q <= ~win_d;
              done1_q <= win_d;
              state_q <= S_ZERO;
            end else begin
              start_q <= 1'b1;
              state_q <= S_START;
            end
          end
        end
        S_START: begin
          busy_cnt_q <= '0;
          state_q    <= S_BUSY;
        end
        S_BUSY: begin
          if (tx_done) begin
            done0_q   <= ~sel_q;
            done1_q   <= sel_q;
            grant0_q  <= 1'b0;
            grant1_q  <= 1'b0;
            prio_q    <= ~sel_q;
            gap_cnt_q <= GW'(GAP_CYCLES);
            state_q   <= S_GAP;
          end else if (busy_cnt_q == TW'(TIMEOUT - 1)) begin
            tout_q    <= 1'b1;
            grant0_q  <= 1'b0;
            grant1_q  <= 1'b0;
            prio_q    <= ~sel_q;
            gap_cnt_q <= GW'(GAP_CYCLES);
            state_q   <= S_GAP;
          end else begin
            busy_cnt_q <= busy_cnt_q + TW'(1);
          end
        end
        S_ZERO: begin
          grant0_q <= 1'b0;
          grant1_q <= 1'b0;
          prio_q   <= ~sel_q;
          state_q  <= S_IDLE;
        end
        S_GAP: begin
          // GAP always occupies at least one clock, even with GAP_CYCLES=0.
          if (gap_cnt_q <= GW'(1)) state_q <= S_IDLE;
          else gap_cnt_q <= gap_cnt_q - GW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q == S_BUSY);
  assign tx_data     = !busy ? '0 : (sel_q ? ch1_data : ch0_data);
  assign ch0_rd      = busy && !sel_q && tx_req;
  assign ch1_rd      = busy && sel_q && tx_req;
  assign ch0_grant   = grant0_q;
  assign ch1_grant   = grant1_q;
  assign ch0_done    = done0_q;
  assign ch1_done    = done1_q;
  assign tx_start_en = start_q;
  assign tx_byte_num = byte_num_q;
  assign timeout_err = tout_q;

endmodule

// File: doc/udp_tx_arb.md
UDP_TX_ARB -- requirements
Module: udp_tx_arb

Interface
REQ-001 Parameter GAP_CYCLES, default 24, sets the number of idle clocks after each packet (inter-frame gap at nibble rate).
REQ-002 Parameter TIMEOUT, default 65535, sets the maximum BUSY clocks allowed before tx_done is declared lost.
REQ-003 clk  input  1  MII transmit clock; all logic is synchronous to its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 ch0_req, ch1_req  input  1 each  level packet request from requester 0/1, held until chN_done.
REQ-006 ch0_byte_num, ch1_byte_num  input  16 each  payload bytes of the pending packet, stable while chN_req=1.
REQ-007 ch0_data, ch1_data  input  32 each  payload word presented in response to chN_rd.
REQ-008 ch0_rd, ch1_rd  output  1 each  payload read strobe forwarded to the granted requester.
REQ-009 ch0_grant, ch1_grant  output  1 each  requester owns the UDP transmit path.
REQ-010 ch0_done, ch1_done  output  1 each  one-clock completion pulse to the owning requester.
REQ-011 tx_start_en  output  1  one-clock start pulse to the UDP sender.
REQ-012 tx_byte_num  output  16  registered byte count for the sender.
REQ-013 tx_data  output  32  payload word muxed from the granted requester.
REQ-014 tx_req  input  1  payload read request from the sender.
REQ-015 tx_done  input  1  one-clock packet-sent pulse from the sender.
REQ-016 timeout_err  output  1  one-clock pulse when TIMEOUT expires in BUSY.

Function
REQ-017 The FSM SHALL have states IDLE, START, BUSY, ZERO, GAP.
REQ-018 In IDLE, with any chN_req=1, the block SHALL select a winner by round-robin: the requester not served last wins a tie; a lone requester always wins.
REQ-019 On selection, the winner's grant SHALL assert, tx_byte_num SHALL load its chN_byte_num, and the FSM SHALL go to START; if that byte_num is 0, it SHALL go to ZERO instead.
REQ-020 START SHALL last exactly one clock with tx_start_en=1, then go to BUSY.
REQ-021 In BUSY, tx_data SHALL equal the granted chN_data combinationally.
REQ-022 In BUSY, chN_rd SHALL equal tx_req for the granted channel and 0 for the other.
REQ-023 In BUSY, tx_done=1 SHALL pulse the granted chN_done the next clock, drop grant, load the gap counter, and go to GAP.
REQ-024 The BUSY counter SHALL clear on entering BUSY and increment each clock.
REQ-025 If the BUSY counter reaches TIMEOUT-1 without tx_done, the block SHALL pulse timeout_err for one clock and go to GAP; chN_done SHALL NOT pulse.
REQ-026 If tx_done and timeout coincide, tx_done SHALL win: chN_done pulses and timeout_err stays 0.
REQ-027 ZERO SHALL last one clock, pulse the granted chN_done, drop grant, and return to IDLE with no gap and no tx_start_en.
REQ-028 GAP SHALL last GAP_CYCLES clocks, then return to IDLE; GAP_CYCLES=0 SHALL return to IDLE on the next clock.
REQ-029 On leaving BUSY or ZERO, the last-served pointer SHALL update to the served channel.
REQ-030 Outside BUSY, tx_data SHALL be 0, both chN_rd SHALL be 0, and tx_req and tx_done SHALL be ignored.
REQ-031 Deassertion of chN_req after grant SHALL NOT abort the packet.
REQ-032 At most one chN_grant SHALL be 1 at any time.

Reset
REQ-033 While rst=1, the FSM SHALL be IDLE; all outputs, counters and tx_byte_num SHALL be 0; the pointer SHALL favour ch0.
REQ-034 rst asserted mid-packet SHALL abort immediately, with no chN_done or timeout_err pulse.

Verification
REQ-035 Scenario: ch0_req=1, ch0_byte_num=100 -> ch0_grant=1; tx_start_en pulses 2 clocks after req; tx_done -> ch0_done pulses 1 clock later; IDLE after 24 gap clocks.
REQ-036 Scenario: ch0 and ch1 request together, both persistent -> grants alternate ch0, ch1, ch0, ch1 across four packets.
REQ-037 Scenario: ch1 granted, tx_req pulses with ch1_data=32'hDEADBEEF -> ch1_rd=tx_req, tx_data=32'hDEADBEEF, ch0_rd=0.
REQ-038 Scenario: TIMEOUT=16, tx_done never sent -> timeout_err pulses after 16 BUSY clocks, no done pulse, next request served after the gap.
REQ-039 Scenario: ch1_byte_num=0 -> ch1_done pulses with no tx_start_en, FSM returns to IDLE with no gap.
REQ-040 Scenario: rst=1 in BUSY -> all outputs 0 asynchronously; after release, ch0 wins a simultaneous request.
